// File: rtl/multicycle_controller_if.sv
// Handshake and control bundle between the multi-cycle control FSM and its datapath.
// Pure wiring; no storage, no latency.
// No backpressure: mem_ack is the only stall source and it is consumed by the FSM.
interface multicycle_controller_if #(
  parameter int CNT_W = 6
);
  logic             start;
  logic [CNT_W-1:0] no_instruct;
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ack;

  logic             ir_write;
  logic             mem_req;
  logic             mem_we;
  logic             reg_write;
  logic [1:0]       wb_sel;
  logic             alu_src_a_pc;
  logic [1:0]       pc_sel;
  logic             next_instruct;
  logic [CNT_W-1:0] instr_count;
  logic             eof;
  logic             illegal;
  logic             bus_err;
  logic [2:0]       state;

  // Datapath / stimulus side
  modport master (
    output start, no_instruct, opcode, branch_taken, mem_ack,
    input  ir_write, mem_req, mem_we, reg_write, wb_sel, alu_src_a_pc,
           pc_sel, next_instruct, instr_count, eof, illegal, bus_err, state
  );

  // Controller side
  modport slave (
    input  start, no_instruct, opcode, branch_taken, mem_ack,
    output ir_write, mem_req, mem_we, reg_write, wb_sel, alu_src_a_pc,
           pc_sel, next_instruct, instr_count, eof, illegal, bus_err, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for the unpipelined RV32I core: fetch/decode/exec/mem/wb/pc-update sequencing.
// Latency: branch 4, ALU/jump/lui/auipc 5, store 5+waits, load 6+waits cycles per instruction.
// Stalls in MEM while mem_ack is low; halts with bus_err after MEM_TIMEOUT unacked cycles.
module multicycle_controller #(
  parameter int CNT_W       = 6,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_controller_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_PCUPD  = 3'd6;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [3:0] C_R      = 4'd0;
  localparam logic [3:0] C_I      = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_STORE  = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_JAL    = 4'd5;
  localparam logic [3:0] C_JALR   = 4'd6;
  localparam logic [3:0] C_LUI    = 4'd7;
  localparam logic [3:0] C_AUIPC  = 4'd8;
  localparam logic [3:0] C_NONE   = 4'd15;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       cls_q, dec_cls;
  logic [CNT_W-1:0] limit_q, count_q, count_inc;
  logic             taken_q;
  logic [WAIT_W-1:0] wait_q;
  logic             eof_q, illegal_q, bus_err_q;
  logic [1:0]       wb_sel_c, pc_sel_c;

  assign count_inc = count_q + CNT_W'(1);

  // Map the raw opcode onto an instruction class; unknown opcodes become C_NONE
  always_comb begin
    dec_cls = C_NONE;
    case (bus.opcode)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
      7'b1100111: dec_cls = C_JALR;
      7'b0110111: dec_cls = C_LUI;
      7'b0010111: dec_cls = C_AUIPC;
      default:    dec_cls = C_NONE;
    endcase
  end

  // Next-state selection; the ack wins over the timeout in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = (bus.no_instruct == '0) ? S_HALT : S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = (dec_cls == C_NONE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEM;
        else if (cls_q == C_BRANCH)              state_d = S_PCUPD;
        else                                     state_d = S_WB;
      end
      S_MEM: begin
        if (bus.mem_ack)                               state_d = (cls_q == C_LOAD) ? S_WB : S_PCUPD;
        else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1))   state_d = S_HALT;
      end
      S_WB:     state_d = S_PCUPD;
      S_PCUPD:  state_d = (count_inc == limit_q) ? S_HALT : S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // State, latched operands, counters and sticky halt causes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cls_q     <= C_R;
      limit_q   <= '0;
      count_q   <= '0;
      taken_q   <= 1'b0;
      wait_q    <= '0;
      eof_q     <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.start) limit_q <= bus.no_instruct;
      if (state_q == S_DECODE)            cls_q   <= dec_cls;
      if (state_q == S_EXEC)              taken_q <= bus.branch_taken;
      if (state_q == S_PCUPD)             count_q <= count_inc;
      if (state_q == S_MEM && !bus.mem_ack) wait_q <= wait_q + WAIT_W'(1);
      else                                  wait_q <= '0;
      // The state we leave from tells which halt cause applies
      if (state_d == S_HALT && state_q != S_HALT) begin
        eof_q     <= (state_q == S_IDLE) || (state_q == S_PCUPD);
        illegal_q <= (state_q == S_DECODE);
        bus_err_q <= (state_q == S_MEM);
      end
    end
  end

  // Writeback source and PC select are only non-zero in their own state
  always_comb begin
    wb_sel_c = 2'd0;
    pc_sel_c = 2'd0;
    if (state_q == S_WB) begin
      case (cls_q)
        C_LOAD:         wb_sel_c = 2'd1;
        C_JAL, C_JALR:  wb_sel_c = 2'd2;
        C_LUI:          wb_sel_c = 2'd3;
        default:        wb_sel_c = 2'd0;
      endcase
    end
    if (state_q == S_PCUPD) begin
      if (cls_q == C_JAL || (cls_q == C_BRANCH && taken_q)) pc_sel_c = 2'd1;
      else if (cls_q == C_JALR)                            pc_sel_c = 2'd2;
    end
  end

  assign bus.ir_write      = (state_q == S_FETCH);
  assign bus.mem_req       = (state_q == S_MEM);
  assign bus.mem_we        = (state_q == S_MEM) && (cls_q == C_STORE);
  assign bus.reg_write     = (state_q == S_WB);
  assign bus.alu_src_a_pc  = (state_q == S_EXEC) && (cls_q == C_AUIPC);
  assign bus.next_instruct = (state_q == S_PCUPD);
  assign bus.wb_sel        = wb_sel_c;
  assign bus.pc_sel        = pc_sel_c;
  assign bus.instr_count   = count_q;
  assign bus.eof           = eof_q;
  assign bus.illegal       = illegal_q;
  assign bus.bus_err       = bus_err_q;
  assign bus.state         = state_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the RV32I multi-cycle, unpipelined core. Sequences each instruction through fetch, decode, execute, memory and writeback.
- Issues the single-cycle `next_instruct` pulse and the `pc_sel` select that drive the program counter. Counts retired instructions against a programmed limit and raises `eof`.
- Sits between the instruction register/decoder and the PC, register file, ALU and data-memory interface.

Parameters:
- CNT_W, 6, width of the instruction limit and retired-instruction counter.
- MEM_TIMEOUT, 15, maximum cycles spent in MEM waiting for `mem_ack` before a bus-error halt.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-low reset.
- start  input  1  level; sampled in IDLE to begin execution.
- no_instruct  input  CNT_W  number of instructions to execute; latched when leaving IDLE.
- opcode  input  7  instruction[6:0] from the instruction register; valid from DECODE onward.
- branch_taken  input  1  ALU compare result; sampled in EXEC.
- mem_ack  input  1  data-memory completion.
- ir_write  output  1  load the instruction register.
- mem_req  output  1  data-memory access request.
- mem_we  output  1  1 = store, 0 = load; valid with `mem_req`.
- reg_write  output  1  register-file write enable.
- wb_sel  output  2  0 = ALU, 1 = memory data, 2 = pc+4, 3 = immediate.
- alu_src_a_pc  output  1  ALU operand A = PC (AUIPC).
- pc_sel  output  2  0 = pc+4, 1 = pc+imm, 2 = rs1+imm (JALR).
- next_instruct  output  1  one-cycle PC update strobe.
- instr_count  output  CNT_W  retired instructions.
- eof  output  1  program complete.
- illegal  output  1  unsupported opcode halt.
- bus_err  output  1  memory timeout halt.
- state  output  3  current FSM state, for debug.

Behaviour:
- **Reset:** a `rst` low sampled at a rising `clk` edge puts state in IDLE (0) and clears every output, `instr_count`, the latched limit, the class register, the latched `branch_taken` and the wait counter. Reset mid-instruction abandons it; no `next_instruct` is emitted.
- **State encoding:** IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, PCUPD = 6, HALT = 7.
- **Output style:** outputs are Moore, decoded from the registered state and the registered opcode class. There is no combinational input-to-output path.
- **IDLE:**
  - If `start` = 1, latch `no_instruct`.
  - If the latched value is 0, go to HALT with `eof` = 1; otherwise go to FETCH.
- **FETCH:** `ir_write` = 1; go to DECODE.
- **DECODE:** classify `opcode` and register the class.
  - Supported opcodes: R = 0110011, I = 0010011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011, JAL = 1101111, JALR = 1100111, LUI = 0110111, AUIPC = 0010111.
  - Any other opcode: go to HALT with `illegal` = 1; `instr_count` is unchanged.
  - Otherwise go to EXEC.
- **EXEC:**
  - `alu_src_a_pc` = 1 for AUIPC.
  - Latch `branch_taken` (meaningful for BRANCH only).
  - Next state: LOAD/STORE → MEM; BRANCH → PCUPD; all others → WB.
- **MEM:**
  - `mem_req` = 1; `mem_we` = 1 for STORE.
  - Stay in MEM while `mem_ack` = 0.
  - When `mem_ack` = 1: LOAD → WB, STORE → PCUPD. The same-cycle ack counts, so a zero-wait access spends 1 cycle in MEM.
  - The wait counter increments each MEM cycle without ack. On reaching MEM_TIMEOUT with no ack: go to HALT with `bus_err` = 1 and deassert `mem_req`.
- **WB:**
  - `reg_write` = 1.
  - `wb_sel`: LOAD = 1; JAL/JALR = 2; LUI = 3; R/I/AUIPC = 0.
  - Go to PCUPD.
- **PCUPD:**
  - `next_instruct` = 1 for exactly one cycle.
  - `pc_sel`: JAL = 1; BRANCH with latched taken = 1; JALR = 2; otherwise 0.
  - `instr_count` increments on exit.
  - If `instr_count` + 1 == latched limit: go to HALT with `eof` = 1; otherwise go to FETCH.
- **HALT:** terminal state.
  - All strobes are 0.
  - `eof`, `illegal` and `bus_err` hold (sticky) until reset.
  - `start` is ignored.
- **Latency (cycles):**
  - BRANCH: 4.
  - R, I, JAL, JALR, LUI, AUIPC: 5.
  - STORE: 5 + waits.
  - LOAD: 6 + waits.
- **Counter:** `instr_count` never wraps. With the limit at 2^CNT_W−1 = 63, execution halts at 63.
- **Exclusivity:** at most one of `ir_write`, `mem_req`, `reg_write`, `next_instruct` is high in any cycle.

Test Plan:
- Reset, `start` = 1, `no_instruct` = 2, opcodes R then LUI → states 0,1,2,3,5,6,1,2,3,5,6,7. `next_instruct` is high exactly twice with `pc_sel` = 0. `wb_sel` = 0 then 3. `eof` = 1 in cycle 11; `instr_count` = 2.
- BRANCH with `branch_taken` = 1, then a second BRANCH with `branch_taken` = 0 → first PCUPD has `pc_sel` = 1, second has `pc_sel` = 0, and `reg_write` is never asserted. JALR → `pc_sel` = 2, `wb_sel` = 2.
- LOAD with `mem_ack` delayed 3 cycles → `mem_req` is high for 4 cycles with `mem_we` = 0, then WB with `wb_sel` = 1. STORE with immediate ack → 1 MEM cycle, `mem_we` = 1, no WB.
- `mem_ack` held at 0 → after 15 MEM cycles go to HALT, `bus_err` = 1, `mem_req` = 0, no `next_instruct`.
- Opcode 1111111 → HALT after DECODE, `illegal` = 1, `instr_count` unchanged. Separately, `no_instruct` = 0 → IDLE goes straight to HALT, `eof` = 1, `ir_write` never asserted.
- `rst` = 0 asserted during MEM with `mem_req` high → next cycle IDLE, all outputs 0. Restart with `start` runs normally.
